const_div_seq_ctrl: RTL and testbench

//  Sequencer for a digit-serial divide-by-constant unit. Takes a WIDTH-bit

---
 rtl/const_div_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_const_div_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/const_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : const_div_seq_ctrl
// Purpose  : Digit-serial divide-by-constant sequencer. A WIDTH-bit unsigned
//            dividend is consumed MSB-first, CHUNK bits per cycle, through one
//            shared remainder-chained digit stage:
//                t       = r * 2^CHUNK + chunk
//                digit   = t / DIVISOR   (CHUNK bits)
//                r_next  = t % DIVISOR
//            The full quotient and remainder are returned over a valid/ready
//            handshake.
//
// Ports    : clk        rising-edge clock
//            rst        asynchronous, active-high reset
//            in_valid   dividend offered
//            in_ready   controller accepts a dividend this cycle (IDLE only)
//            in_data    unsigned dividend, WIDTH bits
//            out_valid  result held (DONE state)
//            out_ready  collector takes result this cycle
//            out_quot   quotient, WIDTH bits
//            out_rem    remainder, REM_W bits, always < DIVISOR
//            busy       high while digits are being produced (RUN)
//
// Timing   : accept cycle, then WIDTH/CHUNK RUN cycles, then DONE. With
//            out_ready held high one operation completes every
//            WIDTH/CHUNK + 2 cycles.
//
// Revision : 1.0  initial release
// ============================================================================
module const_div_seq_ctrl #(
    parameter int WIDTH   = 48,
    parameter int CHUNK   = 6,
    parameter int DIVISOR = 47,
    parameter int REM_W   = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [REM_W-1:0] out_rem,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int STEPS  = WIDTH / CHUNK;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    // Width of the partial dividend t = {r, chunk}. Since r < DIVISOR,
    // t < DIVISOR * 2^CHUNK, so the digit always fits in CHUNK bits.
    localparam int T_W    = REM_W + CHUNK;

    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(STEPS - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_shift;   // remaining dividend bits, MSB-aligned
    logic [WIDTH-1:0]  r_quot;    // quotient digits shifted in from the right
    logic [REM_W-1:0]  r_rem;     // running remainder, always < DIVISOR
    logic [STEP_W-1:0] r_step;

    // ------------------------------------------------------------------------
    // Combinational digit stage
    // ------------------------------------------------------------------------
    logic [T_W-1:0]    w_t;
    logic [T_W-1:0]    w_acc;
    logic [CHUNK-1:0]  w_digit;
    logic              w_accept;
    logic              w_release;

    assign w_t = {r_rem, r_shift[WIDTH-1 -: CHUNK]};

    // Restoring long division against the constant: one compare/subtract per
    // digit bit, each against DIVISOR shifted to that bit position. All
    // comparands are elaboration-time constants, so this reduces to a fixed
    // chain of constant comparators and subtractors with no multiplier.
    always_comb begin
        w_acc   = w_t;
        w_digit = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (w_acc >= (T_W'(DIVISOR) << i)) begin
                w_acc      = w_acc - (T_W'(DIVISOR) << i);
                w_digit[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // in_ready is forced low while reset is asserted so that nothing upstream
    // sees a ready controller before reset has been released.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_release = (r_state == S_DONE) && out_ready;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_step  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= in_data;
                        r_quot  <= '0;
                        r_rem   <= '0;
                        r_step  <= '0;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    // After the last digit the residue of w_acc is the final
                    // remainder; its upper CHUNK bits are zero by construction.
                    r_rem   <= REM_W'(w_acc);
                    r_quot  <= {r_quot[WIDTH-CHUNK-1:0], w_digit};
                    r_shift <= r_shift << CHUNK;
                    r_step  <= r_step + 1'b1;
                    if (r_step == c_last_step) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Result is held until the collector takes it; a new
                    // dividend can be accepted from the following cycle.
                    if (w_release) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign out_quot  = r_quot;
    assign out_rem   = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_const_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_const_div_seq_ctrl
// Purpose  : Scoreboard bench for const_div_seq_ctrl. Stimulus pushes the
//            expected quotient/remainder when a dividend is accepted; a
//            separate monitor pops and compares on every output handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_const_div_seq_ctrl;

    localparam int W   = 48;
    localparam int RW  = 6;
    localparam int DIV = 47;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_quot;
    logic [RW-1:0] out_rem;
    logic          busy;

    int errors;
    int checks;

    logic [W-1:0]  exp_q [$];
    logic [RW-1:0] exp_r [$];

    bit bp_en;
    bit ready_force;

    const_div_seq_ctrl #(
        .WIDTH   (W),
        .CHUNK   (6),
        .DIVISOR (DIV),
        .REM_W   (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] x);
        logic [63:0] xx;
        xx = {16'd0, x};
        exp_q.push_back(W'(xx / DIV));
        exp_r.push_back(RW'(xx % DIV));
    endtask

    // Offer x until accepted. push: record expectation. garbage: while the
    // operation is in flight, toggle in_valid with random data (must be
    // ignored), returning once the controller is back in IDLE.
    task automatic send(input logic [W-1:0] x, input bit push, input bit garbage);
        int n;
        in_data  = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) push_exp(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (garbage) begin
            n = 0;
            while (!in_ready && n < 200) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {16'($urandom), $urandom};
                @(posedge clk); #1;
                n++;
            end
            in_valid = 1'b0;
            if (!in_ready) check("complete_timeout", 64'd0, 64'd1);
        end
    endtask

    // Collector readiness, updated away from the edges used by the driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: a handshake seen at the falling edge completes at the next
    // rising edge, and out_valid is gone by the following falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    check("quot", {16'd0, out_quot}, {16'd0, exp_q.pop_front()});
                    check("rem", {58'd0, out_rem}, {58'd0, exp_r.pop_front()});
                end
            end
        end
    end

    initial begin
        int  n;
        bit  seen;
        logic [W-1:0] x;

        errors      = 0;
        checks      = 0;
        bp_en       = 1'b0;
        ready_force = 1'b1;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_quot", {16'd0, out_quot}, 64'd0);
        check("rst_rem", {58'd0, out_rem}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // 47 -> (1,0); out_valid in the 9th cycle after the accept cycle
        @(posedge clk); #1;
        in_data  = 48'd47;
        in_valid = 1'b1;
        push_exp(48'd47);
        n = 0;
        @(posedge clk); #1;
        n++;
        in_valid = 1'b0;
        check("busy_in_run", {63'd0, busy}, 64'd1);
        check("in_ready_in_run", {63'd0, in_ready}, 64'd0);
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 64'd9);
        check("busy_in_done", {63'd0, busy}, 64'd0);

        // All-ones dividend
        send(48'hFFFF_FFFF_FFFF, 1'b1, 1'b0);
        check("q_max_const", 64'd5988829291716 * 47 + 3, 64'hFFFF_FFFF_FFFF);

        // Back-to-back 0 then 46 (second offered during first's RUN/DONE)
        send(48'd0, 1'b1, 1'b0);
        send(48'd46, 1'b1, 1'b0);

        // Stall: result held 20 cycles with collector not ready
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ready_force = 1'b0;
        @(posedge clk); #1;
        send(48'd1000000, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_data  = 48'd12345;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_quot", {16'd0, out_quot}, 64'd21276);
            check("stall_rem", {58'd0, out_rem}, 64'd28);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        ready_force = 1'b1;
        n = 0;
        while (out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_release", {63'd0, out_valid}, 64'd0);
        check("stall_sb_empty", exp_q.size(), 64'd0);

        // Reset during RUN step 4: no result, then 94 -> (2,0)
        send(48'hABCD_EF01_2345, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_quot", {16'd0, out_quot}, 64'd0);
        check("midrst_rem", {58'd0, out_rem}, 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_output", {63'd0, seen}, 64'd0);
        @(posedge clk); #1;
        send(48'd94, 1'b1, 1'b0);

        // Random dividends, random backpressure, in_valid noise during RUN/DONE
        bp_en = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            case (k % 4)
                0:       x = W'($urandom_range(0, 200));
                1:       x = 48'hFFFF_FFFF_FFFF - W'($urandom_range(0, 100));
                2:       x = W'(64'd47 * $urandom_range(0, 1000000));
                default: x = {16'($urandom), $urandom};
            endcase
            send(x, 1'b1, 1'b1);
        end
        bp_en = 1'b0;
        ready_force = 1'b1;

        // Drain
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("final_sb_empty", exp_q.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
